// File: rtl/i2c_slave_regmap_if.sv
// Bus bundle between the i2c_slave core/host fabric and the register-map controller.
// slave = controller side, master = core + fabric side.
interface i2c_slave_regmap_if #(
  parameter int ADDR_W = 4
);
  logic              i2c_busy;
  logic              i2c_newData;
  logic              i2c_dataReq;
  logic [7:0]        i2c_rx_data;
  logic [7:0]        i2c_tx_data;
  logic [ADDR_W-1:0] host_addr;
  logic              host_we;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] ptr;
  logic              addr_err;

  modport slave (
    input  i2c_busy, i2c_newData, i2c_dataReq, i2c_rx_data,
    input  host_addr, host_we, host_wdata,
    output i2c_tx_data, host_rdata, wr_strobe, wr_addr, ptr, addr_err
  );

  modport master (
    output i2c_busy, i2c_newData, i2c_dataReq, i2c_rx_data,
    output host_addr, host_we, host_wdata,
    input  i2c_tx_data, host_rdata, wr_strobe, wr_addr, ptr, addr_err
  );
endinterface

// File: rtl/i2c_slave_regmap.sv
// Pointer-addressed register bank behind the i2c_slave core: first written byte sets the
// pointer, later bytes write/read with auto-increment; a host port shares the bank.
module i2c_slave_regmap #(
  parameter int               DEPTH   = 16,
  parameter int               ADDR_W  = 4,
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input logic               clk,
  input logic               rst,
  i2c_slave_regmap_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_PTR, S_DATA} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_busy_q, r_nd_q, r_dr_q;
  logic              w_busy_rise, w_busy_fall, w_nd_rise, w_dr_rise;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc, r_wr_addr;
  logic              w_i2c_wr, w_err, r_wr_strobe, r_addr_err;
  logic [7:0]        r_regs [DEPTH];
  logic [7:0]        r_tx, r_hrd;

  assign w_busy_rise = bus.i2c_busy & ~r_busy_q;
  assign w_busy_fall = ~bus.i2c_busy & r_busy_q;
  assign w_nd_rise   = bus.i2c_newData & ~r_nd_q;
  assign w_dr_rise   = bus.i2c_dataReq & ~r_dr_q;
  assign w_ptr_inc   = (r_ptr == ADDR_W'(DEPTH-1)) ? '0 : r_ptr + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy_q <= 1'b0;
      r_nd_q   <= 1'b0;
      r_dr_q   <= 1'b0;
    end else begin
      r_busy_q <= bus.i2c_busy;
      r_nd_q   <= bus.i2c_newData;
      r_dr_q   <= bus.i2c_dataReq;
    end
  end

  // newData wins over a simultaneous dataReq so the pointer only moves once.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_i2c_wr    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: if (w_busy_rise) w_state_nxt = S_PTR;
      S_PTR: begin
        if (w_nd_rise) begin
          if ({24'd0, bus.i2c_rx_data} < 32'(DEPTH)) w_ptr_nxt = bus.i2c_rx_data[ADDR_W-1:0];
          else begin
            w_ptr_nxt = '0;
            w_err     = 1'b1;
          end
          w_state_nxt = S_DATA;
        end else if (w_dr_rise) begin
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_nd_rise) begin
          w_i2c_wr  = 1'b1;
          w_ptr_nxt = w_ptr_inc;
        end else if (w_dr_rise) w_ptr_nxt = w_ptr_inc;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_busy_fall) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wr_strobe <= w_i2c_wr;
      r_addr_err  <= w_err;
      if (w_i2c_wr) r_wr_addr <= r_ptr;
    end
  end

  // I2C write beats host write on the same register unless that register is read-only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_tx  <= '0;
      r_hrd <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_i2c_wr && r_ptr == ADDR_W'(i) && !RO_MASK[i]) r_regs[i] <= bus.i2c_rx_data;
        else if (bus.host_we && bus.host_addr == ADDR_W'(i)) r_regs[i] <= bus.host_wdata;
      end
      r_tx  <= r_regs[r_ptr];
      r_hrd <= r_regs[bus.host_addr];
    end
  end

  assign bus.i2c_tx_data = r_tx;
  assign bus.host_rdata  = r_hrd;
  assign bus.wr_strobe   = r_wr_strobe;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.ptr         = r_ptr;
  assign bus.addr_err    = r_addr_err;
endmodule

// File: tb/tb_i2c_slave_regmap.sv
// Transaction-level checks of i2c_slave_regmap against an array/pointer model of the bank.
module tb_i2c_slave_regmap;
  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [15:0] RO    = 16'h0002;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_slave_regmap_if #(.ADDR_W(AW)) bus();
  i2c_slave_regmap #(.DEPTH(DEPTH), .ADDR_W(AW), .RO_MASK(RO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int         n_chk = 0, n_err = 0;
  logic [7:0] mem [DEPTH];
  int         mptr = 0;
  bit         first = 1'b0;
  int         exp_err = 0, got_err = 0;
  int         exp_wa[$], got_wa[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.wr_strobe) got_wa.push_back(32'(bus.wr_addr));
    if (bus.addr_err) got_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    mptr = 0;
  endtask

  task automatic chk_strobes();
    chk("strobe_count", 32'(got_wa.size()), 32'(exp_wa.size()));
    for (int i = 0; i < got_wa.size() && i < exp_wa.size(); i++)
      chk("wr_addr", 32'(got_wa[i]), 32'(exp_wa[i]));
    got_wa.delete();
    exp_wa.delete();
    chk("addr_err_count", 32'(got_err), 32'(exp_err));
  endtask

  task automatic start();
    bus.i2c_busy = 1'b1;
    first = 1'b1;
    tick(3);
  endtask

  task automatic stop();
    bus.i2c_busy = 1'b0;
    tick(3);
    chk("ptr_at_stop", 32'(bus.ptr), 32'(mptr));
    chk_strobes();
  endtask

  // One received byte; optionally a host write lands in the very same cycle.
  task automatic wbyte(input logic [7:0] b, input bit hwe = 1'b0,
                       input logic [3:0] ha = 4'd0, input logic [7:0] hd = 8'h00);
    if (hwe) mem[ha] = hd;
    if (first) begin
      if (b < DEPTH) mptr = int'(b);
      else begin
        mptr = 0;
        exp_err++;
      end
      first = 1'b0;
    end else begin
      if (!RO[mptr]) mem[mptr] = b;
      exp_wa.push_back(mptr);
      mptr = (mptr + 1) % DEPTH;
    end
    bus.i2c_rx_data = b;
    bus.i2c_newData = 1'b1;
    bus.host_we     = hwe;
    bus.host_addr   = ha;
    bus.host_wdata  = hd;
    tick(1);
    bus.host_we = 1'b0;
    tick(1);
    bus.i2c_newData = 1'b0;
    tick(2);
  endtask

  // The core samples tx_data when it raises dataReq.
  task automatic rbyte();
    chk("tx_data", 32'(bus.i2c_tx_data), 32'(mem[mptr]));
    mptr = (mptr + 1) % DEPTH;
    first = 1'b0;
    bus.i2c_dataReq = 1'b1;
    tick(2);
    bus.i2c_dataReq = 1'b0;
    tick(2);
  endtask

  task automatic hwr(input int a, input logic [7:0] d);
    bus.host_addr  = 4'(a);
    bus.host_wdata = d;
    bus.host_we    = 1'b1;
    tick(1);
    bus.host_we = 1'b0;
    mem[a] = d;
    tick(1);
  endtask

  task automatic hrd(input int a);
    bus.host_addr = 4'(a);
    tick(1);
    chk("host_rdata", 32'(bus.host_rdata), 32'(mem[a]));
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) hrd(i);
  endtask

  initial begin
    rst = 1'b1;
    bus.i2c_busy = 1'b0; bus.i2c_newData = 1'b0; bus.i2c_dataReq = 1'b0; bus.i2c_rx_data = 8'h00;
    bus.host_addr = '0; bus.host_we = 1'b0; bus.host_wdata = 8'h00;
    model_clear();
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_ptr", 32'(bus.ptr), 32'd0);
    chk("rst_tx", 32'(bus.i2c_tx_data), 32'd0);
    chk("rst_strobe", 32'(bus.wr_strobe), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'd0);

    // preload, then reset must clear the whole bank
    for (int i = 0; i < DEPTH; i++) hwr(i, 8'(8'hA0 + i));
    hrd(7);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    model_clear();
    sweep();
    chk("rst2_ptr", 32'(bus.ptr), 32'd0);
    chk("rst2_tx", 32'(bus.i2c_tx_data), 32'd0);

    // reset in the middle of a write: no strobe, FSM back in IDLE
    start(); wbyte(8'h05); wbyte(8'h99);
    chk_strobes();
    bus.i2c_rx_data = 8'h66; bus.i2c_newData = 1'b1; rst = 1'b1;
    tick(1);
    bus.i2c_busy = 1'b0; bus.i2c_newData = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    model_clear();
    bus.i2c_rx_data = 8'h44; bus.i2c_newData = 1'b1; tick(2);
    bus.i2c_newData = 1'b0; tick(2);
    chk("idle_ptr", 32'(bus.ptr), 32'd0);
    chk_strobes();
    sweep();

    // plain write 3: AA BB CC
    start(); wbyte(8'h03); wbyte(8'hAA); wbyte(8'hBB); wbyte(8'hCC); stop();
    hrd(3); hrd(4); hrd(5);
    // wrap and out-of-range pointer
    start(); wbyte(8'h0F); wbyte(8'h11); wbyte(8'h22); stop();
    hrd(15); hrd(0);
    start(); wbyte(8'h20); stop();
    // pointer then read transaction
    start(); wbyte(8'h04); stop();
    start(); rbyte(); rbyte(); rbyte(); stop();
    // read-only register
    start(); wbyte(8'h01); wbyte(8'h55); stop();
    hrd(1);
    hwr(1, 8'h77); hrd(1);
    // host vs I2C on the same register
    start(); wbyte(8'h02); wbyte(8'h20, 1'b1, 4'd2, 8'h10); stop();
    hrd(2);
    start(); wbyte(8'h01); wbyte(8'h33, 1'b1, 4'd1, 8'h44); stop();
    hrd(1);
    start(); wbyte(8'h02); stop();
    start(); rbyte(); stop();

    // randomized traffic
    repeat (40) begin
      case ($urandom_range(0, 2))
        0: begin
          start();
          wbyte(8'($urandom_range(0, 19)));
          repeat ($urandom_range(0, 5)) begin
            if ($urandom_range(0, 3) == 0)
              wbyte(8'($urandom), 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
            else
              wbyte(8'($urandom));
          end
          stop();
        end
        1: begin
          start();
          repeat ($urandom_range(1, 5)) rbyte();
          stop();
        end
        default: hwr($urandom_range(0, DEPTH-1), 8'($urandom));
      endcase
    end
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regmap.md
Name: i2c_slave_regmap

Overview:
Register-file controller that sits between the `i2c_slave` core and user fabric. It turns the core's byte-level handshakes (`busy`, `newData`, `dataReq`) into a pointer-addressed register bank with auto-increment. The first byte written in each transaction sets the pointer. Later written bytes are stored at the pointer; read bytes are served from the pointer. A local host port gives the fabric random read/write access to the same bank.

Parameters:
DEPTH, 16, number of 8-bit registers (2..256)
ADDR_W, 4, pointer/host address width; must equal ceil(log2(DEPTH))
RO_MASK, 0 (DEPTH bits), bit i set = register i ignores I2C writes (host writes still apply)

Ports:
clk  input  1  system clock; i2c_slave core runs on the same clock
rst  input  1  reset, asynchronous, active-high
i2c_busy  input  1  core busy flag; high for the duration of an addressed transaction
i2c_newData  input  1  core flag; rising edge = received byte valid on i2c_rx_data
i2c_dataReq  input  1  core flag; rising edge = core has sampled i2c_tx_data and will shift it out
i2c_rx_data  input  8  byte received by core
i2c_tx_data  output  8  byte offered to core for the next read
host_addr  input  ADDR_W  host register address
host_we  input  1  host write enable, single-cycle
host_wdata  input  8  host write data
host_rdata  output  8  registered read of regs[host_addr]
wr_strobe  output  1  one-cycle pulse on each I2C register write
wr_addr  output  ADDR_W  register index written; valid with wr_strobe
ptr  output  ADDR_W  current register pointer
addr_err  output  1  one-cycle pulse when the pointer byte is >= DEPTH

Behaviour:
- Reset state: all regs = 0, ptr = 0, i2c_tx_data = 0, host_rdata = 0, wr_strobe = 0, wr_addr = 0, addr_err = 0, FSM = IDLE.
- Reset is asynchronous and may occur mid-transaction: everything clears at once, and no write or strobe completes.
- Edge detection: previous-cycle copies of busy, newData and dataReq are registered. All events are the rise or fall of these flags and are acted on one clk after the flag changes. Inputs need no synchroniser.
- FSM states and transitions:
  - IDLE: busy rise -> PTR.
  - PTR: newData rise -> pointer-byte handling (below), then -> DATA.
  - PTR: dataReq rise -> ptr <= ptr+1 (read without pointer write), then -> DATA.
  - DATA: newData rise -> I2C write at ptr (below), ptr <= ptr+1.
  - DATA: dataReq rise -> ptr <= ptr+1.
  - Any state: busy fall -> IDLE. ptr is retained, so a following read transaction continues from the last pointer.
- Pointer-byte handling: byte < DEPTH -> ptr <= byte. Byte >= DEPTH -> ptr <= 0 and addr_err pulses one cycle.
- I2C write at ptr: regs[ptr] <= i2c_rx_data unless RO_MASK[ptr] = 1. wr_strobe and wr_addr = ptr are asserted either way, so the fabric sees the attempt.
- Pointer increment wraps from DEPTH-1 to 0.
- i2c_tx_data is registered and equals regs[ptr] one cycle after any change to ptr or regs[ptr]. The core samples it at dataReq rise; the controller then advances ptr. Net result: the first byte read is regs[ptr], then the following registers in order.
- Edge events and busy fall in the same cycle: the edge event is processed first, then the FSM goes to IDLE.
- newData rise and dataReq rise in the same cycle are illegal core behaviour. If it happens, newData takes priority and ptr advances by exactly 1.
- Host port:
  - host_rdata <= regs[host_addr] every cycle (latency 1).
  - host_we writes regs[host_addr] regardless of RO_MASK.
  - If host_we and an I2C write target the same register in the same cycle, the I2C write wins. If that register is read-only, the host write applies.
- No output is combinational from an input.

Test Plan:
1. Reset with regs preloaded via host -> every host_rdata reads 0x00, ptr = 0, i2c_tx_data = 0x00; assert rst while in DATA -> FSM is IDLE and no wr_strobe occurs.
2. I2C write 0x03, 0xAA, 0xBB, 0xCC -> regs[3..5] = AA, BB, CC; three wr_strobe pulses with wr_addr 3, 4, 5; ptr = 6 at busy fall.
3. Write 0x0F then 0x11, 0x22 with DEPTH = 16 -> regs[15] = 0x11, regs[0] = 0x22, ptr = 1 (wrap). Then pointer byte 0x20 -> addr_err pulses once and ptr = 0.
4. Write pointer 0x04, busy fall, then read transaction with 3 dataReq rises -> i2c_tx_data sampled at each rise = regs[4], regs[5], regs[6]; ptr = 7.
5. RO_MASK = 0x0002: I2C write 0x01, 0x55 -> regs[1] unchanged and wr_strobe with wr_addr = 1; host write regs[1] = 0x77 -> host_rdata = 0x77.
6. host_we to addr 2 with 0x10 in the same cycle as an I2C write of 0x20 to addr 2 -> regs[2] = 0x20 and i2c_tx_data updates one cycle later.
